change_dispenser: RTL and testbench

//   Payout end of the vending-machine change path. Takes a change amount (NT$) from
//   the vending FSM and drives one coin-ejector pulse per coin, largest coin first (50/10/5/1).

---
 rtl/change_dispenser_if.sv | 38 +++
 rtl/change_dispenser.sv | 192 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
//  Module      : change_if
//  Description : Handshake, payout and status bundle between the vending FSM
//                (master) and the change dispenser (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface change_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
) ();
    logic             change_valid;
    logic [AMT_W-1:0] change_amt;
    logic             change_ready;
    logic             refill;
    logic [3:0]       coin_out;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] stock50;
    logic [CNT_W-1:0] stock10;
    logic [CNT_W-1:0] stock5;
    logic [CNT_W-1:0] stock1;

    modport master (
        output change_valid, change_amt, refill,
        input  change_ready, coin_out, busy, done, short, remaining,
               stock50, stock10, stock5, stock1
    );

    modport slave (
        input  change_valid, change_amt, refill,
        output change_ready, coin_out, busy, done, short, remaining,
               stock50, stock10, stock5, stock1
    );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays out a change amount as coin-ejector pulses, largest
//                coin first (50/10/5/1), tracking per-tube stock and flagging
//                a shortfall when the tubes cannot cover the amount.
//  Revision    : 1.0  initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 6,
    parameter int STOCK_MAX = 20,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    change_if.slave   bus
);

    // Timer must reach the longer of the pulse and gap phases.
    localparam int c_TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int c_TW      = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam logic [c_TW-1:0]  c_PULSE_LAST = c_TW'(PULSE_CYC - 1);
    localparam logic [c_TW-1:0]  c_GAP_LAST   = c_TW'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_STOCK_MAX  = CNT_W'(STOCK_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [c_TW-1:0]  r_tmr;
    logic [1:0]       r_coin;        // tube index: 3=50 2=10 1=5 0=1
    logic [AMT_W-1:0] r_remaining;
    logic             r_short;
    logic [CNT_W-1:0] r_stock [4];

    logic             w_sel_ok;
    logic [1:0]       w_sel_idx;
    logic [AMT_W-1:0] w_coin_val;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic [3:0]       w_coin_out;

    // Face value of a tube index.
    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd3:    coin_value = AMT_W'(50);
            2'd2:    coin_value = AMT_W'(10);
            2'd1:    coin_value = AMT_W'(5);
            default: coin_value = AMT_W'(1);
        endcase
    endfunction

    // Largest coin that fits the amount owed and whose tube is not empty.
    always_comb begin
        w_sel_ok  = 1'b1;
        w_sel_idx = 2'd0;
        if (r_remaining >= coin_value(2'd3) && r_stock[3] != '0) begin
            w_sel_idx = 2'd3;
        end else if (r_remaining >= coin_value(2'd2) && r_stock[2] != '0) begin
            w_sel_idx = 2'd2;
        end else if (r_remaining >= coin_value(2'd1) && r_stock[1] != '0) begin
            w_sel_idx = 2'd1;
        end else if (r_remaining >= coin_value(2'd0) && r_stock[0] != '0) begin
            w_sel_idx = 2'd0;
        end else begin
            w_sel_ok  = 1'b0;
        end
    end

    assign w_coin_val = coin_value(r_coin);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        w_coin_out = 4'b0000;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (bus.change_valid) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                // A zero amount also fails selection, so one test covers both ends.
                w_next = w_sel_ok ? S_PULSE : S_DONE;
            end
            S_PULSE: begin
                w_coin_out = 4'b0001 << r_coin;
                if (r_tmr == c_PULSE_LAST) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_tmr == c_GAP_LAST) begin
                    w_next = S_SELECT;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Phase timer, amount owed, shortfall flag, chosen coin and tube stock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr       <= '0;
            r_coin      <= 2'd0;
            r_remaining <= '0;
            r_short     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stock[i] <= c_STOCK_MAX;
            end
        end else begin
            // Timer restarts on every phase change.
            if ((r_state == S_PULSE || r_state == S_GAP) && w_next == r_state) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.change_valid) begin
                        r_remaining <= bus.change_amt;
                        r_short     <= 1'b0;
                    end else if (bus.refill) begin
                        for (int i = 0; i < 4; i++) begin
                            r_stock[i] <= c_STOCK_MAX;
                        end
                    end
                end
                S_SELECT: begin
                    if (w_sel_ok) begin
                        r_coin <= w_sel_idx;
                    end else begin
                        r_short <= (r_remaining != '0);
                    end
                end
                S_PULSE: begin
                    // Debit once, on the first cycle of the pulse; selection
                    // guarantees both operands cover the subtraction.
                    if (r_tmr == '0) begin
                        r_remaining     <= r_remaining - w_coin_val;
                        r_stock[r_coin] <= r_stock[r_coin] - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.change_ready = w_ready;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.coin_out     = w_coin_out;
    assign bus.short        = r_short;
    assign bus.remaining    = r_remaining;
    assign bus.stock50      = r_stock[3];
    assign bus.stock10      = r_stock[2];
    assign bus.stock5       = r_stock[1];
    assign bus.stock1       = r_stock[0];

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Directed, table-driven bench for change_dispenser with hand
//                sequences for busy-time requests, refill collision and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_change_dispenser;

    localparam int AMT_W     = 8;
    localparam int CNT_W     = 6;
    localparam int STOCK_MAX = 20;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    change_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .AMT_W    (AMT_W),
        .CNT_W    (CNT_W),
        .STOCK_MAX(STOCK_MAX),
        .PULSE_CYC(PULSE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          refill;   // refill in IDLE before the request
        logic [7:0]  amt;
        int          n;        // number of coins expected
        logic [31:0] coins;    // coin_out of each pulse, first coin in low nibble
        logic [7:0]  rem;
        bit          sh;
        int          s50, s10, s5, s1;
        int          lat;      // cycles from accept to done
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [3:0] coin_q [$];
    logic [3:0] prev_coin = 4'b0;
    int         width     = 0;
    int         done_cnt  = 0;
    bit         chk_width = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: records each coin, checks one-hot and pulse width, counts done.
    always @(negedge clk) begin
        if (bus.coin_out != 4'b0 && prev_coin == 4'b0) begin
            coin_q.push_back(bus.coin_out);
            chk("coin_onehot", 32'($onehot(bus.coin_out)), 32'd1);
        end
        if (bus.coin_out != 4'b0) begin
            width = (prev_coin == 4'b0) ? 1 : width + 1;
        end else if (prev_coin != 4'b0 && chk_width) begin
            chk("pulse_width", width, PULSE_CYC);
        end
        if (bus.done) done_cnt++;
        prev_coin = bus.coin_out;
    end

    // One request: optional refill, accept, wait for done, check results.
    // with_refill raises refill together with the request; noise re-raises
    // change_valid (amt=20) while the payout is busy.
    task automatic run_vec(input vec_t v, input bit with_refill, input bit noise);
        int  g;
        int  k;
        bit  seen;
        if (v.refill) begin
            bus.refill = 1'b1;
            @(posedge clk); #1;
            bus.refill = 1'b0;
        end
        coin_q.delete();
        bus.change_valid = 1'b1;
        bus.change_amt   = v.amt;
        bus.refill       = with_refill;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.change_ready && g < 50);
        if (!bus.change_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.change_valid = 1'b0;
        bus.refill       = 1'b0;
        k    = 1;
        seen = 1'b0;
        while (k <= 200 && !seen) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
                if (noise && k <= 7) begin
                    bus.change_valid = 1'b1;
                    bus.change_amt   = 8'd20;
                end else begin
                    bus.change_valid = 1'b0;
                    bus.change_amt   = v.amt;
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", k, v.lat);
        chk("remaining", 32'(bus.remaining), 32'(v.rem));
        chk("short_at_done", 32'(bus.short), 32'(v.sh));
        chk("stock50", 32'(bus.stock50), v.s50);
        chk("stock10", 32'(bus.stock10), v.s10);
        chk("stock5", 32'(bus.stock5), v.s5);
        chk("stock1", 32'(bus.stock1), v.s1);
        chk("coin_count", coin_q.size(), v.n);
        for (int j = 0; j < v.n && j < coin_q.size(); j++) begin
            chk("coin_value", 32'(coin_q[j]), 32'(v.coins[4*j +: 4]));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after", 32'(bus.change_ready), 32'd1);
        chk("busy_after", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("short_held", 32'(bus.short), 32'(v.sh));
        chk("no_extra_coins", coin_q.size(), v.n);
        @(posedge clk); #1;
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        //            refill amt    n  coins         rem  sh  s50 s10 s5 s1 lat
        tbl[0]  = '{1'b0, 8'd67,  5, 32'h00011248, 8'd0, 1'b0, 19, 19, 19, 18, 22};
        tbl[1]  = '{1'b0, 8'd0,   0, 32'h0,        8'd0, 1'b0, 19, 19, 19, 18, 2};
        tbl[2]  = '{1'b0, 8'd16,  3, 32'h00000124, 8'd0, 1'b0, 19, 18, 18, 17, 14};
        tbl[3]  = '{1'b0, 8'd100, 2, 32'h00000088, 8'd0, 1'b0, 17, 18, 18, 17, 10};
        // row 4 runs after stock1 has been drained to zero
        tbl[4]  = '{1'b0, 8'd3,   0, 32'h0,        8'd3, 1'b1, 17, 18, 18, 0,  2};
        tbl[5]  = '{1'b1, 8'd3,   3, 32'h00000111, 8'd0, 1'b0, 20, 20, 20, 17, 14};
        tbl[6]  = '{1'b0, 8'd250, 5, 32'h00088888, 8'd0, 1'b0, 15, 20, 20, 17, 22};
        tbl[7]  = '{1'b0, 8'd250, 5, 32'h00088888, 8'd0, 1'b0, 10, 20, 20, 17, 22};
        tbl[8]  = '{1'b0, 8'd250, 5, 32'h00088888, 8'd0, 1'b0, 5,  20, 20, 17, 22};
        tbl[9]  = '{1'b0, 8'd250, 5, 32'h00088888, 8'd0, 1'b0, 0,  20, 20, 17, 22};
        tbl[10] = '{1'b0, 8'd55,  6, 32'h00244444, 8'd0, 1'b0, 0,  15, 19, 17, 26};

        bus.change_valid = 1'b0;
        bus.change_amt   = 8'd0;
        bus.refill       = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.change_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_short", 32'(bus.short), 32'd0);
        chk("rst_coin", 32'(bus.coin_out), 32'd0);
        chk("rst_remaining", 32'(bus.remaining), 32'd0);
        chk("rst_stock", {bus.stock50, bus.stock10, bus.stock5, bus.stock1},
            {CNT_W'(20), CNT_W'(20), CNT_W'(20), CNT_W'(20)});
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(tbl[i], 1'b0, 1'b0);

        // Drain the 1-coin tube: 17 single-coin requests.
        for (int i = 0; i < 17; i++) begin
            v = '{1'b0, 8'd1, 1, 32'h1, 8'd0, 1'b0, 17, 18, 18, 16 - i, 6};
            run_vec(v, 1'b0, 1'b0);
        end

        for (int i = 4; i < 11; i++) run_vec(tbl[i], 1'b0, 1'b0);

        // Requests raised while busy are ignored.
        v = '{1'b0, 8'd16, 3, 32'h00000124, 8'd0, 1'b0, 0, 14, 18, 16, 14};
        run_vec(v, 1'b0, 1'b1);

        // Request and refill together: accept wins, no reload (stock50 stays 0).
        v = '{1'b0, 8'd1, 1, 32'h1, 8'd0, 1'b0, 0, 14, 18, 15, 6};
        run_vec(v, 1'b1, 1'b0);

        // Reset during the second pulse of a 67 payout.
        coin_q.delete();
        bus.change_valid = 1'b1;
        bus.change_amt   = 8'd67;
        @(posedge clk); #1;
        bus.change_valid = 1'b0;
        begin
            int g;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (bus.coin_out != 4'b0100 && g < 50);
            chk("second_pulse_seen", 32'(bus.coin_out), 32'h4);
        end
        chk_width = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_coin", 32'(bus.coin_out), 32'd0);
        chk("rst_mid_remaining", 32'(bus.remaining), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_stock", {bus.stock50, bus.stock10, bus.stock5, bus.stock1},
            {CNT_W'(20), CNT_W'(20), CNT_W'(20), CNT_W'(20)});
        done_cnt = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        chk_width = 1'b1;
        @(posedge clk); #1;

        v = '{1'b0, 8'd67, 5, 32'h00011248, 8'd0, 1'b0, 19, 19, 19, 18, 22};
        run_vec(v, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait escapes its bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
